// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Round-robin arbiter that packs up to N finished functional-unit results
//   per cycle onto N registered CDB lanes feeding the complete stage.
//
// Ports
//   clock          : single clock, all state changes on its rising edge
//   reset          : synchronous, active-low reset
//   req_valid      : [NUM_REQ] FU i holds a finished result
//   req_entry      : [NUM_REQ] payload of FU i (held stable until granted)
//   req_grant      : [NUM_REQ] combinational grant, transfer this cycle
//   flush          : squash, blocks every transfer in the current cycle
//   cdb_valid      : [N] registered lane-valid bits
//   cdb_entry      : [N] registered lane payloads (zero when lane unused)
//   conflict_count : saturating count of non-flush cycles with > N requests

`ifndef N
`define N 3
`endif

package cdb_pkg;
  // Opaque result payload; the arbiter never looks inside it.
  typedef struct packed {
    logic [5:0]  rob_idx;
    logic        mispredict;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [6:0]  dest_pr;
    logic [31:0] result;
  } ex_complete_entry_t;
endpackage

module cdb_arbiter #(
  parameter int N       = `N,
  parameter int NUM_REQ = 6
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  cdb_pkg::ex_complete_entry_t    req_entry [NUM_REQ],
  output logic [NUM_REQ-1:0]             req_grant,
  input  logic                           flush,
  output logic [N-1:0]                   cdb_valid,
  output cdb_pkg::ex_complete_entry_t    cdb_entry [N],
  output logic [15:0]                    conflict_count
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LANE_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0]            rr_ptr_r;
  logic [PTR_W-1:0]            rr_ptr_nxt_s;
  logic [NUM_REQ-1:0]          grant_s;
  logic [N-1:0]                lane_valid_s;
  cdb_pkg::ex_complete_entry_t lane_entry_s [N];
  logic                        overload_s;
  int                          req_cnt_s;
  int                          gcnt_s;
  int                          idx_s;

  logic [N-1:0]                cdb_valid_r;
  cdb_pkg::ex_complete_entry_t cdb_entry_r [N];
  logic [15:0]                 conflict_count_r;

  // Count requests (for overload detection) independent of reset/flush.
  always_comb begin
    req_cnt_s = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        req_cnt_s = req_cnt_s + 1;
      end else begin
        req_cnt_s = req_cnt_s;
      end
    end
  end

  // Round-robin scan from rr_ptr: grant the first N valid requesters and
  // pack them into lanes in scan order; pointer follows the last grant.
  always_comb begin
    grant_s      = '0;
    lane_valid_s = '0;
    for (int k = 0; k < N; k++) begin
      lane_entry_s[k] = '0;
    end
    rr_ptr_nxt_s = rr_ptr_r;
    gcnt_s       = 0;
    idx_s        = 0;
    if (reset && !flush) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        idx_s = (int'(rr_ptr_r) + j) % NUM_REQ;
        if (req_valid[PTR_W'(idx_s)] && (gcnt_s < N)) begin
          grant_s[PTR_W'(idx_s)]       = 1'b1;
          lane_valid_s[LANE_W'(gcnt_s)] = 1'b1;
          lane_entry_s[LANE_W'(gcnt_s)] = req_entry[PTR_W'(idx_s)];
          rr_ptr_nxt_s                 = PTR_W'((idx_s + 1) % NUM_REQ);
          gcnt_s                       = gcnt_s + 1;
        end else begin
          gcnt_s = gcnt_s;
        end
      end
    end else begin
      gcnt_s = 0;
    end
  end

  // Flush and reset both suppress the overload count.
  always_comb begin
    if (reset && !flush && (req_cnt_s > N)) begin
      overload_s = 1'b1;
    end else begin
      overload_s = 1'b0;
    end
  end

  // Lane registers, round-robin pointer and saturating conflict counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cdb_valid_r <= '0;
      for (int k = 0; k < N; k++) begin
        cdb_entry_r[k] <= '0;
      end
      rr_ptr_r         <= '0;
      conflict_count_r <= 16'h0000;
    end else begin
      cdb_valid_r <= lane_valid_s;
      for (int k = 0; k < N; k++) begin
        cdb_entry_r[k] <= lane_entry_s[k];
      end
      rr_ptr_r <= rr_ptr_nxt_s;
      if (overload_s && (conflict_count_r != 16'hFFFF)) begin
        conflict_count_r <= conflict_count_r + 16'd1;
      end else begin
        conflict_count_r <= conflict_count_r;
      end
    end
  end

  assign req_grant      = grant_s;
  assign cdb_valid      = cdb_valid_r;
  assign cdb_entry      = cdb_entry_r;
  assign conflict_count = conflict_count_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with N=3, NUM_REQ=6.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic                clock;
  logic                reset;
  logic [5:0]          req_valid;
  ex_complete_entry_t  req_entry [6];
  logic [5:0]          req_grant;
  logic                flush;
  logic [2:0]          cdb_valid;
  ex_complete_entry_t  cdb_entry [3];
  logic [15:0]         conflict_count;

  int total;
  int bad;

  cdb_arbiter #(.N(3), .NUM_REQ(6)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_entry(req_entry), .req_grant(req_grant),
    .flush(flush), .cdb_valid(cdb_valid), .cdb_entry(cdb_entry),
    .conflict_count(conflict_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Distinct payload per FU; FU 4 carries rob_idx 9.
  function automatic ex_complete_entry_t mk(input int i);
    ex_complete_entry_t e;
    e.rob_idx       = 6'(i + 5);
    e.mispredict    = (i % 2) == 1;
    e.branch_taken  = (i % 2) == 0;
    e.branch_target = 32'hA000_0000 + 32'(i);
    e.dest_pr       = 7'(i + 32);
    e.result        = 32'hC0DE_0000 + 32'(i * 17);
    return e;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check all three lanes against expected valid bits and payloads.
  task automatic check_lanes(input string tag, input logic [2:0] v,
                             input ex_complete_entry_t e0, input ex_complete_entry_t e1,
                             input ex_complete_entry_t e2);
    check({tag, ".valid"}, 128'(cdb_valid), 128'(v));
    check({tag, ".lane0"}, 128'(cdb_entry[0]), 128'(e0));
    check({tag, ".lane1"}, 128'(cdb_entry[1]), 128'(e1));
    check({tag, ".lane2"}, 128'(cdb_entry[2]), 128'(e2));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    ex_complete_entry_t z;
    z     = '0;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 6; i++) req_entry[i] = mk(i);
    flush     = 1'b0;
    reset     = 1'b0;
    req_valid = 6'b111111;

    // Reset held with every requester valid.
    #1;
    check("rst.grant", 128'(req_grant), 128'(6'b000000));
    tick();
    check_lanes("rst", 3'b000, z, z, z);
    check("rst.cnt", 128'(conflict_count), 128'(16'h0000));
    check("rst.ptr", 128'(dut.rr_ptr_r), 128'(3'd0));

    // Single requester 4 from pointer 0.
    reset     = 1'b1;
    req_valid = 6'b010000;
    #1;
    check("one.grant", 128'(req_grant), 128'(6'b010000));
    tick();
    check_lanes("one", 3'b001, mk(4), z, z);
    check("one.rob", 128'(cdb_entry[0].rob_idx), 128'(6'd9));
    check("one.ptr", 128'(dut.rr_ptr_r), 128'(3'd5));

    // Mid-operation reset returns pointer to 0 and drops lanes.
    reset     = 1'b0;
    req_valid = 6'b000001;
    #1;
    check("mrst.grant", 128'(req_grant), 128'(6'b000000));
    tick();
    check_lanes("mrst", 3'b000, z, z, z);
    check("mrst.ptr", 128'(dut.rr_ptr_r), 128'(3'd0));

    // All six valid: first three win, then the remaining three.
    reset     = 1'b1;
    req_valid = 6'b111111;
    #1;
    check("all1.grant", 128'(req_grant), 128'(6'b000111));
    tick();
    check_lanes("all1", 3'b111, mk(0), mk(1), mk(2));
    check("all1.ptr", 128'(dut.rr_ptr_r), 128'(3'd3));
    check("all1.cnt", 128'(conflict_count), 128'(16'd1));
    req_valid = 6'b111000;
    #1;
    check("all2.grant", 128'(req_grant), 128'(6'b111000));
    tick();
    check_lanes("all2", 3'b111, mk(3), mk(4), mk(5));
    check("all2.ptr", 128'(dut.rr_ptr_r), 128'(3'd0));
    check("all2.cnt", 128'(conflict_count), 128'(16'd1));

    // Move pointer to 5, then wrap-around grant 5,0,1.
    req_valid = 6'b010000;
    tick();
    check("pre.ptr", 128'(dut.rr_ptr_r), 128'(3'd5));
    req_valid = 6'b101011;
    #1;
    check("wrap.grant", 128'(req_grant), 128'(6'b100011));
    tick();
    check_lanes("wrap", 3'b111, mk(5), mk(0), mk(1));
    check("wrap.ptr", 128'(dut.rr_ptr_r), 128'(3'd2));
    check("wrap.cnt", 128'(conflict_count), 128'(16'd2));
    req_valid = 6'b001000;
    #1;
    check("wrap2.grant", 128'(req_grant), 128'(6'b001000));
    tick();
    check_lanes("wrap2", 3'b001, mk(3), z, z);
    check("wrap2.ptr", 128'(dut.rr_ptr_r), 128'(3'd4));

    // Flush during overload: no grant, no count.
    flush     = 1'b1;
    req_valid = 6'b111111;
    #1;
    check("fovl.grant", 128'(req_grant), 128'(6'b000000));
    tick();
    check_lanes("fovl", 3'b000, z, z, z);
    check("fovl.cnt", 128'(conflict_count), 128'(16'd2));
    check("fovl.ptr", 128'(dut.rr_ptr_r), 128'(3'd4));

    // Flush with reqs 0 and 2, then both granted after release.
    req_valid = 6'b000101;
    #1;
    check("fl.grant", 128'(req_grant), 128'(6'b000000));
    tick();
    check_lanes("fl", 3'b000, z, z, z);
    check("fl.ptr", 128'(dut.rr_ptr_r), 128'(3'd4));
    flush = 1'b0;
    #1;
    check("fl2.grant", 128'(req_grant), 128'(6'b000101));
    tick();
    check_lanes("fl2", 3'b011, mk(0), mk(2), z);
    check("fl2.ptr", 128'(dut.rr_ptr_r), 128'(3'd3));

    // Sustained 6-way overload up to saturation.
    req_valid = 6'b111111;
    #1;
    check("sat.grant", 128'(req_grant), 128'(6'b111000));
    for (int c = 0; c < 65532; c++) @(posedge clock);
    #1;
    check("sat.fffe", 128'(conflict_count), 128'(16'hFFFE));
    tick();
    check("sat.ffff", 128'(conflict_count), 128'(16'hFFFF));
    tick();
    tick();
    check("sat.hold", 128'(conflict_count), 128'(16'hFFFF));
    check("sat.valid", 128'(cdb_valid), 128'(3'b111));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N, default `N, number of complete/CDB lanes driven into the complete stage.
REQ-002 Parameter NUM_REQ, default 6, number of functional-unit requesters; NUM_REQ >= N shall hold.
REQ-003 clock  in  1  single clock; all state updates on posedge clock.
REQ-004 reset  in  1  synchronous, active-low reset; sampled on posedge clock.
REQ-005 req_valid  in  NUM_REQ  FU i holds a finished result.
REQ-006 req_entry  in  NUM_REQ x EX_COMPLETE_ENTRY  result payload of FU i (rob_idx, branch fields, dest_pr, result).
REQ-007 req_grant  out  NUM_REQ  combinational; FU i's payload is accepted this cycle.
REQ-008 flush  in  1  mispredict squash; blocks all transfers this cycle.
REQ-009 cdb_valid  out  N  registered lane-valid bits to the complete stage.
REQ-010 cdb_entry  out  N x EX_COMPLETE_ENTRY  registered lane payloads.
REQ-011 conflict_count  out  16  saturating count of cycles with more than N requests.

Function
REQ-012 Handshake: transfer occurs when req_valid[i] && req_grant[i]; the FU shall hold req_valid and req_entry stable until granted; the arbiter shall never grant when req_valid[i]=0.
REQ-013 Priority: round-robin starting at pointer rr_ptr (log2(NUM_REQ) bits); scan order rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ.
REQ-014 Per cycle, grant the first min(N, popcount(req_valid)) valid requesters in scan order; no others.
REQ-015 Lane packing: the k-th granted requester in scan order occupies lane k; lanes 0..g-1 are used, where g is the number of grants.
REQ-016 Latency: the granted payload appears on cdb_entry[k] with cdb_valid[k]=1 exactly one cycle after the grant.
REQ-017 Lanes k >= g shall have cdb_valid[k]=0 and cdb_entry[k]=all-zeros the next cycle.
REQ-018 Payloads pass through unmodified, including the mispredict and branch fields; no field is interpreted.
REQ-019 Pointer update: if g>0, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ; if g=0, rr_ptr is unchanged.
REQ-020 Fairness: any requester holding req_valid shall be granted within ceil(NUM_REQ/N) cycles, excluding flush cycles.
REQ-021 Flush: while flush=1, req_grant shall be all zeros; the next cycle cdb_valid=0 and cdb_entry=0; rr_ptr and conflict_count are unchanged.
REQ-022 conflict_count increments by 1 in any non-flush cycle with popcount(req_valid) > N; it saturates at 16'hFFFF.
REQ-023 Simultaneous flush and overload: flush has priority, so neither a grant nor a counter increment occurs.

Reset
REQ-024 While reset=0, req_grant shall be all zeros, independent of req_valid.
REQ-025 At the posedge with reset=0: cdb_valid=0, cdb_entry=0, rr_ptr=0, conflict_count=0.
REQ-026 Reset asserted mid-operation discards in-flight registered lanes; the first cycle after release behaves as the post-reset state with rr_ptr=0.

Verification (N=3, NUM_REQ=6)
REQ-027 Reset held with req_valid=6'b111111: req_grant=0, and all outputs are zero after the posedge.
REQ-028 Only req 4 valid, rob_idx=9, rr_ptr=0: req_grant=6'b010000 in the same cycle; next cycle cdb_valid=3'b001, cdb_entry[0].rob_idx=9, rr_ptr=5.
REQ-029 All 6 valid from rr_ptr=0:
- cycle 1: grants 0,1,2 fill lanes 0,1,2; rr_ptr becomes 3; conflict_count becomes 1.
- cycle 2, after the FUs drop reqs 0-2: grants 3,4,5; rr_ptr becomes 0; conflict_count stays 1.
REQ-030 Wrap-around: rr_ptr=5 with reqs 0,1,3,5 valid gives grants 5,0,1 in lanes 0,1,2 respectively; rr_ptr becomes 2; req 3 is granted next cycle.
REQ-031 flush=1 with reqs 0,2 valid: req_grant=0; next cycle cdb_valid=0; rr_ptr is unchanged; both reqs are granted in the first cycle after flush deasserts.
REQ-032 Counter saturation: with conflict_count preloaded near 16'hFFFF by sustained 6-way requests, the count holds at 16'hFFFF and does not wrap.
